vga_scanout: RTL and testbench
==============================

VGA_SCANOUT -- requirements
Module: vga_scanout

Interface
REQ-001 SHALL accept parameter H_ACTIVE, default 800, visible pixels per line.
REQ-002 SHALL accept parameters H_FP/H_SYNC/H_BP, defaults 40/128/88, horizontal porch and sync widths in pixels.
REQ-003 SHALL accept parameters V_ACTIVE/V_FP/V_SYNC/V_BP, defaults 600/1/4/23, vertical timing in lines.
REQ-004 SHALL accept parameters HS_POL/VS_POL, default 1/1, active level of each sync.
REQ-005 SHALL accept parameter CLK_DIV, default 2, even and at least 2, CLOCK_50 cycles per pixel.
REQ-006 SHALL accept parameter ADDR_W, default clog2(H_ACTIVE*V_ACTIVE), framebuffer address width.
REQ-007 CLOCK_50  in  1  sole clock, all logic on rising edge.
REQ-008 RESET  in  1  asynchronous, active-high reset.
REQ-009 mode  in  2  pixel format: 00 RGB888, 01 RGB565, 10 GRAY8, 11 test bars.
REQ-010 fb_addr  out  ADDR_W  framebuffer read address.
REQ-011 fb_rd_en  out  1  one-cycle read strobe.
REQ-012 fb_rdata  in  24  read data, valid exactly 1 CLOCK_50 cycle after fb_rd_en.
REQ-013 frame_start  out  1  one-cycle pulse at start of each frame.
REQ-014 VGA_R/VGA_G/VGA_B  out  8 each  pixel colour to DAC.
REQ-015 VGA_HS/VGA_VS  out  1  syncs; VGA_BLANK_N  out  1  low outside active area; VGA_SYNC_N  out  1  constant 1; VGA_CLK  out  1  DAC latch clock.

Function
REQ-016 SHALL generate a pixel step every CLK_DIV CLOCK_50 cycles from a divider counter.
REQ-017 SHALL advance h_cnt 0..H_TOTAL-1 per pixel step, H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; v_cnt 0..V_TOTAL-1 advances on h_cnt wrap; both wrap to 0.
REQ-018 SHALL assert HS during h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC), VS likewise for v_cnt, at the level given by HS_POL/VS_POL.
REQ-019 SHALL hold active area as h_cnt<H_ACTIVE and v_cnt<V_ACTIVE.
REQ-020 SHALL pulse fb_rd_en on the pixel step of every active pixel, with fb_addr = v_cnt*H_ACTIVE + h_cnt computed by an incrementing counter (no multiplier) that resets to 0 at frame wrap.
REQ-021 SHALL capture fb_rdata one CLOCK_50 cycle after fb_rd_en and drive VGA_R/G/B, VGA_HS, VGA_VS, VGA_BLANK_N together on the next pixel step: fixed 1-pixel-step latency from counter state to outputs.
REQ-022 SHALL format RGB888 as R=[23:16], G=[15:8], B=[7:0].
REQ-023 SHALL format RGB565 from [15:0], widening each field by replicating its MSBs into the low bits.
REQ-024 SHALL format GRAY8 as R=G=B=[7:0].
REQ-025 SHALL in test-bar mode issue no reads and output 8 equal-width vertical bars in order white, yellow, cyan, green, magenta, red, blue, black (full-scale 0xFF/0x00 channels).
REQ-026 SHALL drive R/G/B to 0 whenever VGA_BLANK_N is 0.
REQ-027 SHALL sample mode only at frame wrap (h_cnt=0, v_cnt=0); a mid-frame change takes effect next frame.
REQ-028 SHALL pulse frame_start for one CLOCK_50 cycle on the pixel step where both counters wrap to 0.
REQ-029 SHALL drive VGA_CLK low on the pixel step and high CLK_DIV/2 cycles later, so the DAC latches mid-pixel.

Reset
REQ-030 SHALL on RESET clear divider, h_cnt, v_cnt, fb_addr, fb_rd_en, frame_start, VGA_R/G/B, VGA_CLK and VGA_BLANK_N to 0.
REQ-031 SHALL on RESET drive VGA_HS/VGA_VS to inactive level and VGA_SYNC_N to 1, and latch mode as RGB888.
REQ-032 SHALL after RESET deassertion start at h_cnt=0, v_cnt=0 and emit frame_start on the first pixel step; reset mid-frame abandons the frame with no partial reads.

Structure
REQ-033 SHALL place the mode enumeration, default timing constants and test-bar colour table in package vga_pkg.
REQ-034 SHALL implement counters, sync and active decode in sub-module vga_timing; vga_scanout adds divider, fetch, formatting and output registers.

Verification
REQ-035 Defaults, RESET released: HS period 1056 pixel steps (2112 cycles), active-level HS 128 steps, VS period 628 lines, VS active 4 lines, frame_start every 1,326,336 cycles.
REQ-036 RGB888 with fb_rdata=addr pattern: pixel (h=5,v=2) outputs address 1605 data; fb_addr reaches 479999 last and wraps to 0.
REQ-037 RGB565 fb_rdata=0xF800 -> R=0xFF,G=0x00,B=0x00; 0x07E0 -> G=0xFF; GRAY8 0x80 -> R=G=B=0x80.
REQ-038 mode switched to 11 mid-frame: current frame unchanged; next frame 100-pixel bars, no fb_rd_en pulses.
REQ-039 RESET pulsed mid-line: all outputs at reset values same cycle; after release first frame_start on first pixel step.
REQ-040 HS_POL=0, VS_POL=0, small timing (H 8/1/2/1, V 4/1/1/1): syncs active-low at correct counts; blanked pixels R=G=B=0.

Source files
------------

// File: rtl/vga_pkg.sv
// vga_pkg: shared definitions for the VGA scanout block.
//   - pix_mode_e : framebuffer pixel format selected by the 'mode' input
//   - DEF_*      : default 800x600 timing (pixels / lines) and clock divide
//   - bar_colour : colour of each of the eight vertical test bars
//   - rgb565_to_888 : widens a 5/6/5 pixel to 8/8/8 by MSB replication
package vga_pkg;

  typedef enum logic [1:0] {
    MODE_RGB888 = 2'b00,
    MODE_RGB565 = 2'b01,
    MODE_GRAY8  = 2'b10,
    MODE_BARS   = 2'b11
  } pix_mode_e;

  localparam int DEF_H_ACTIVE = 800;
  localparam int DEF_H_FP     = 40;
  localparam int DEF_H_SYNC   = 128;
  localparam int DEF_H_BP     = 88;
  localparam int DEF_V_ACTIVE = 600;
  localparam int DEF_V_FP     = 1;
  localparam int DEF_V_SYNC   = 4;
  localparam int DEF_V_BP     = 23;
  localparam int DEF_CLK_DIV  = 2;

  localparam int NUM_BARS = 8;

  // Left to right: white, yellow, cyan, green, magenta, red, blue, black.
  function automatic logic [23:0] bar_colour(input logic [2:0] idx);
    logic [23:0] rgb;
    rgb = 24'h000000;
    case (idx)
      3'd0: rgb = 24'hFFFFFF;
      3'd1: rgb = 24'hFFFF00;
      3'd2: rgb = 24'h00FFFF;
      3'd3: rgb = 24'h00FF00;
      3'd4: rgb = 24'hFF00FF;
      3'd5: rgb = 24'hFF0000;
      3'd6: rgb = 24'h0000FF;
      default: rgb = 24'h000000;
    endcase
    return rgb;
  endfunction

  function automatic logic [23:0] rgb565_to_888(input logic [15:0] p);
    return {p[15:11], p[15:13], p[10:5], p[10:9], p[4:0], p[4:2]};
  endfunction

endpackage

// File: rtl/vga_timing.sv
// vga_timing: horizontal/vertical raster counters and their decode.
// Ports:
//   clk, rst    - clock and asynchronous active-high reset
//   step        - one-cycle pixel step; counters advance only on it
//   active      - current pixel lies in the visible area
//   hs_on/vs_on - current pixel lies in the sync interval (active-high, raw)
//   line_end    - current pixel is the last of its line
//   frame_wrap  - current pixel is (0,0), the first of a frame
module vga_timing
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter int H_W      = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP),
  parameter int V_W      = $clog2(V_ACTIVE + V_FP + V_SYNC + V_BP)
) (
  input  logic clk,
  input  logic rst,
  input  logic step,
  output logic active,
  output logic hs_on,
  output logic vs_on,
  output logic line_end,
  output logic frame_wrap
);

  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END   = VS_START + V_SYNC;

  logic [H_W-1:0] h_cnt;
  logic [V_W-1:0] v_cnt;

  assign line_end = (h_cnt == H_W'(H_TOTAL - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (step) begin
      if (line_end) begin
        h_cnt <= '0;
        v_cnt <= (v_cnt == V_W'(V_TOTAL - 1)) ? '0 : v_cnt + V_W'(1);
      end else begin
        h_cnt <= h_cnt + H_W'(1);
      end
    end
  end

  assign active     = (h_cnt < H_W'(H_ACTIVE)) && (v_cnt < V_W'(V_ACTIVE));
  assign hs_on      = (h_cnt >= H_W'(HS_START)) && (h_cnt < H_W'(HS_END));
  assign vs_on      = (v_cnt >= V_W'(VS_START)) && (v_cnt < V_W'(VS_END));
  assign frame_wrap = (h_cnt == '0) && (v_cnt == '0);

endmodule

// File: rtl/vga_scanout.sv
// vga_scanout: reads a framebuffer in raster order and drives a VGA DAC.
// Ports:
//   CLOCK_50, RESET        - sole clock; asynchronous active-high reset
//   mode[1:0]              - pixel format, sampled at the start of each frame
//   fb_addr, fb_rd_en      - framebuffer read request (one-cycle strobe)
//   fb_rdata[23:0]         - read data, one cycle after the strobe
//   frame_start            - one-cycle pulse on the step of pixel (0,0)
//   VGA_R/G/B, VGA_HS/VS   - colour and syncs, registered on the pixel step
//   VGA_BLANK_N            - low outside the visible area
//   VGA_SYNC_N             - tied high
//   VGA_CLK                - low on the pixel step, high half a pixel later
//
// Read handshake: there is no back-pressure. When fb_rd_en is high for one
// cycle, fb_addr is valid in that cycle and the memory must present
// fb_rdata in exactly the following cycle; the block captures it there.
//
// Pipeline: on each pixel step the counter state of the current pixel is
// decoded, its read is issued and its sync/blank/mode are parked in p_*;
// on the following step those are formatted into the output registers,
// giving a fixed one-step latency.
module vga_scanout
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter bit HS_POL   = 1'b1,
  parameter bit VS_POL   = 1'b1,
  parameter int CLK_DIV  = DEF_CLK_DIV,
  parameter int ADDR_W   = $clog2(H_ACTIVE * V_ACTIVE)
) (
  input  logic              CLOCK_50,
  input  logic              RESET,
  input  logic [1:0]        mode,
  output logic [ADDR_W-1:0] fb_addr,
  output logic              fb_rd_en,
  input  logic [23:0]       fb_rdata,
  output logic              frame_start,
  output logic [7:0]        VGA_R,
  output logic [7:0]        VGA_G,
  output logic [7:0]        VGA_B,
  output logic              VGA_HS,
  output logic              VGA_VS,
  output logic              VGA_BLANK_N,
  output logic              VGA_SYNC_N,
  output logic              VGA_CLK
);

  localparam int DIV_W  = $clog2(CLK_DIV);
  localparam int BAR_W  = (H_ACTIVE >= NUM_BARS) ? H_ACTIVE / NUM_BARS : 1;
  localparam int BAR_PW = (BAR_W > 1) ? $clog2(BAR_W) : 1;

  logic [DIV_W-1:0]  div_cnt;
  logic              step;
  logic              active, hs_on, vs_on, line_end, frame_wrap;
  pix_mode_e         mode_q, mode_cur;
  logic [ADDR_W-1:0] addr_cnt, addr_base;
  logic [BAR_PW-1:0] bar_pos;
  logic [2:0]        bar_idx;
  logic              rd_pend;
  logic [23:0]       rdata_q, src, fmt;
  logic              p_active, p_hs, p_vs;
  pix_mode_e         p_mode;
  logic [2:0]        p_bar;

  // The step is the cycle in which the divider sits at zero, so the first
  // clock after reset release is already a pixel step.
  assign step = (div_cnt == '0);

  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      div_cnt <= '0;
      VGA_CLK <= 1'b0;
    end else begin
      div_cnt <= (div_cnt == DIV_W'(CLK_DIV - 1)) ? '0 : div_cnt + DIV_W'(1);
      if (step)
        VGA_CLK <= 1'b0;
      else if (div_cnt == DIV_W'(CLK_DIV / 2))
        VGA_CLK <= 1'b1;
    end
  end

  vga_timing #(
    .H_ACTIVE (H_ACTIVE), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
    .V_ACTIVE (V_ACTIVE), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP)
  ) u_timing (
    .clk        (CLOCK_50),
    .rst        (RESET),
    .step       (step),
    .active     (active),
    .hs_on      (hs_on),
    .vs_on      (vs_on),
    .line_end   (line_end),
    .frame_wrap (frame_wrap)
  );

  // Pixel (0,0) already belongs to the new frame, so it uses the live mode.
  assign mode_cur  = frame_wrap ? pix_mode_e'(mode) : mode_q;
  assign addr_base = frame_wrap ? '0 : addr_cnt;

  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      mode_q      <= MODE_RGB888;
      addr_cnt    <= '0;
      fb_addr     <= '0;
      fb_rd_en    <= 1'b0;
      frame_start <= 1'b0;
      bar_pos     <= '0;
      bar_idx     <= '0;
      rd_pend     <= 1'b0;
      rdata_q     <= '0;
      p_active    <= 1'b0;
      p_hs        <= 1'b0;
      p_vs        <= 1'b0;
      p_mode      <= MODE_RGB888;
      p_bar       <= '0;
    end else begin
      fb_rd_en    <= step && active && (mode_cur != MODE_BARS);
      frame_start <= step && frame_wrap;
      rd_pend     <= fb_rd_en;
      if (rd_pend)
        rdata_q <= fb_rdata;
      if (step) begin
        if (frame_wrap)
          mode_q <= pix_mode_e'(mode);
        // Raster address advances once per visible pixel, whatever the mode.
        if (active) begin
          fb_addr  <= addr_base;
          addr_cnt <= addr_base + ADDR_W'(1);
        end
        // Bar index tracks h_cnt incrementally; it saturates at the last bar.
        if (line_end) begin
          bar_pos <= '0;
          bar_idx <= '0;
        end else if (bar_pos == BAR_PW'(BAR_W - 1)) begin
          bar_pos <= '0;
          if (bar_idx != 3'd7)
            bar_idx <= bar_idx + 3'd1;
        end else begin
          bar_pos <= bar_pos + BAR_PW'(1);
        end
        p_active <= active;
        p_hs     <= hs_on;
        p_vs     <= vs_on;
        p_mode   <= mode_cur;
        p_bar    <= bar_idx;
      end
    end
  end

  // With CLK_DIV=2 the read data is still on the bus at the next step, so
  // it is taken directly; for slower steps the captured copy is used.
  always_comb begin
    src = rd_pend ? fb_rdata : rdata_q;
    fmt = '0;
    case (p_mode)
      MODE_RGB888: fmt = src;
      MODE_RGB565: fmt = rgb565_to_888(src[15:0]);
      MODE_GRAY8:  fmt = {3{src[7:0]}};
      default:     fmt = bar_colour(p_bar);
    endcase
  end

  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      VGA_R       <= '0;
      VGA_G       <= '0;
      VGA_B       <= '0;
      VGA_HS      <= ~HS_POL;
      VGA_VS      <= ~VS_POL;
      VGA_BLANK_N <= 1'b0;
    end else if (step) begin
      VGA_BLANK_N           <= p_active;
      VGA_HS                <= p_hs ? HS_POL : ~HS_POL;
      VGA_VS                <= p_vs ? VS_POL : ~VS_POL;
      {VGA_R, VGA_G, VGA_B} <= p_active ? fmt : 24'h000000;
    end
  end

  assign VGA_SYNC_N = 1'b1;

endmodule

// File: tb/tb_vga_scanout.sv
// tb_vga_scanout: randomized scoreboard bench for vga_scanout on a small
// 8x4 raster (H 8/1/2/1, V 4/1/1/1), active-low syncs, CLK_DIV=2.
module tb_vga_scanout;

  localparam int H_ACT = 8, H_FP = 1, H_SY = 2, H_BP = 1;
  localparam int V_ACT = 4, V_FP = 1, V_SY = 1, V_BP = 1;
  localparam int CLK_DIV   = 2;
  localparam int H_TOT     = H_ACT + H_FP + H_SY + H_BP;
  localparam int V_TOT     = V_ACT + V_FP + V_SY + V_BP;
  localparam int FRAME_CYC = H_TOT * V_TOT * CLK_DIV;
  localparam int AW        = 5;
  // {sync_n, blank_n, hs, vs, r, g, b} of the pre-first-pixel output slot
  localparam logic [27:0] IDLE_VEC = {1'b1, 1'b0, 1'b1, 1'b1, 24'h000000};

  // ---------------- clock / reset ----------------
  logic          CLOCK_50 = 1'b0;
  logic          RESET    = 1'b1;
  logic [1:0]    mode     = 2'b00;
  logic [23:0]   fb_rdata = 24'h0;
  logic [AW-1:0] fb_addr;
  logic          fb_rd_en, frame_start;
  logic [7:0]    VGA_R, VGA_G, VGA_B;
  logic          VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N, VGA_CLK;

  always #5 CLOCK_50 = ~CLOCK_50;

  int pc;  // clock edges since reset release; frame k wraps at pc = 1 + k*FRAME_CYC
  always @(posedge CLOCK_50 or posedge RESET)
    if (RESET) pc <= 0;
    else       pc <= pc + 1;

  vga_scanout #(
    .H_ACTIVE (H_ACT), .H_FP (H_FP), .H_SYNC (H_SY), .H_BP (H_BP),
    .V_ACTIVE (V_ACT), .V_FP (V_FP), .V_SYNC (V_SY), .V_BP (V_BP),
    .HS_POL (1'b0), .VS_POL (1'b0), .CLK_DIV (CLK_DIV), .ADDR_W (AW)
  ) dut (
    .CLOCK_50 (CLOCK_50), .RESET (RESET), .mode (mode),
    .fb_addr (fb_addr), .fb_rd_en (fb_rd_en), .fb_rdata (fb_rdata),
    .frame_start (frame_start),
    .VGA_R (VGA_R), .VGA_G (VGA_G), .VGA_B (VGA_B),
    .VGA_HS (VGA_HS), .VGA_VS (VGA_VS), .VGA_BLANK_N (VGA_BLANK_N),
    .VGA_SYNC_N (VGA_SYNC_N), .VGA_CLK (VGA_CLK)
  );

  // ---------------- framebuffer model ----------------
  logic [23:0] mem [32];

  initial begin
    logic          seen;
    logic [AW-1:0] a;
    forever begin
      @(posedge CLOCK_50);
      seen = fb_rd_en;
      a    = fb_addr;
      #1;
      fb_rdata = seen ? mem[a] : 24'($urandom);
    end
  end

  // ---------------- scoreboard state ----------------
  int          n_vec = 0, n_err = 0;
  logic [27:0] exp_q[$];
  logic [1:0]  fmode_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: what the DAC must show for pixel (h,v) of a frame in mode m.
  function automatic logic [27:0] ref_pixel(input logic [1:0] m, input int h, input int v);
    logic [23:0] d;
    int r, g, b, bar;
    logic act, hs, vs;
    act = (h < H_ACT) && (v < V_ACT);
    hs  = !((h >= H_ACT + H_FP) && (h < H_ACT + H_FP + H_SY));
    vs  = !((v >= V_ACT + V_FP) && (v < V_ACT + V_FP + V_SY));
    r = 0; g = 0; b = 0;
    d = act ? mem[v * H_ACT + h] : 24'h0;
    if (act) begin
      case (m)
        2'b00: begin r = int'(d[23:16]); g = int'(d[15:8]); b = int'(d[7:0]); end
        2'b01: begin
          r = int'(d[15:11]) * 8 + int'(d[15:11]) / 4;
          g = int'(d[10:5]) * 4 + int'(d[10:5]) / 16;
          b = int'(d[4:0]) * 8 + int'(d[4:0]) / 4;
        end
        2'b10: begin r = int'(d[7:0]); g = r; b = r; end
        default: begin
          bar = h * 8 / H_ACT;
          r = (bar == 0 || bar == 1 || bar == 4 || bar == 5) ? 255 : 0;
          g = (bar <= 3) ? 255 : 0;
          b = (bar % 2 == 0 && bar != 8) ? ((bar <= 6) ? 255 : 0) : 0;
        end
      endcase
    end
    return {1'b1, act, hs, vs, 8'(r), 8'(g), 8'(b)};
  endfunction

  task automatic push_frame(input logic [1:0] m);
    for (int v = 0; v < V_TOT; v++)
      for (int h = 0; h < H_TOT; h++)
        exp_q.push_back(ref_pixel(m, h, v));
    fmode_q.push_back(m);
  endtask

  task automatic wait_pc(input int t);
    while (pc < t) @(negedge CLOCK_50);
  endtask

  // ---------------- driver tasks ----------------
  task automatic start_session(input logic [1:0] m0);
    mode = m0;
    exp_q.delete();
    fmode_q.delete();
    exp_q.push_back(IDLE_VEC);
    push_frame(m0);
    @(negedge CLOCK_50);
    RESET = 1'b0;
  endtask

  // Frame k runs with the mode set before its wrap; mid-frame the input is
  // scrambled, then the next frame's mode is applied shortly before the wrap.
  task automatic frame_body(input int k, input logic [1:0] next_m, input bit push_next);
    int base;
    base = 1 + FRAME_CYC * k;
    wait_pc(base + int'($urandom_range(2, 120)));
    mode = 2'($urandom);
    wait_pc(base + FRAME_CYC - 10);
    if (push_next) begin
      mode = next_m;
      push_frame(next_m);
    end
  endtask

  task automatic reset_check(input string tag);
    check({tag, "_rgb"},     {8'h0, VGA_R, VGA_G, VGA_B}, 32'h0);
    check({tag, "_blank_n"}, 32'(VGA_BLANK_N), 32'h0);
    check({tag, "_hs"},      32'(VGA_HS), 32'h1);
    check({tag, "_vs"},      32'(VGA_VS), 32'h1);
    check({tag, "_sync_n"},  32'(VGA_SYNC_N), 32'h1);
    check({tag, "_vga_clk"}, 32'(VGA_CLK), 32'h0);
    check({tag, "_rd_en"},   32'(fb_rd_en), 32'h0);
    check({tag, "_addr"},    32'(fb_addr), 32'h0);
    check({tag, "_fs"},      32'(frame_start), 32'h0);
  endtask

  task automatic end_checks(input string tag);
    check({tag, "_frames_seen"}, 32'(fmode_q.size()), 32'h0);
    check({tag, "_pixels_drained"}, 32'(exp_q.size() >= 2 && exp_q.size() <= 10), 32'h1);
  endtask

  // ---------------- monitor ----------------
  logic prev_vclk = 1'b0;
  bit   first_fs  = 1'b1;
  int   last_fs = 0, rd_idx = 0, cur_reads = 0;

  initial begin
    logic [27:0] exp, act;
    logic [1:0]  fm;
    forever begin
      @(negedge CLOCK_50);
      if (RESET) begin
        first_fs  = 1'b1;
        rd_idx    = 0;
        prev_vclk = 1'b0;
      end else begin
        if (frame_start) begin
          if (first_fs) check("fs_first", 32'(pc), 32'd1);
          else begin
            check("fs_period", 32'(pc - last_fs), 32'(FRAME_CYC));
            check("reads_per_frame", 32'(rd_idx), 32'(cur_reads));
          end
          first_fs = 1'b0;
          last_fs  = pc;
          rd_idx   = 0;
          if (fmode_q.size() == 0) check("frame_mode_underflow", 32'h1, 32'h0);
          else begin
            fm = fmode_q.pop_front();
            cur_reads = (fm == 2'b11) ? 0 : H_ACT * V_ACT;
          end
        end
        if (fb_rd_en) begin
          check("fb_addr", 32'(fb_addr), 32'(rd_idx));
          rd_idx++;
        end
        if (VGA_CLK && !prev_vclk) begin
          act = {VGA_SYNC_N, VGA_BLANK_N, VGA_HS, VGA_VS, VGA_R, VGA_G, VGA_B};
          if (exp_q.size() == 0) check("pixel_underflow", 32'h1, 32'h0);
          else begin
            exp = exp_q.pop_front();
            check("pixel", 32'(act), 32'(exp));
          end
        end
        prev_vclk = VGA_CLK;
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [1:0] ms[$];
    for (int i = 0; i < 32; i++) mem[i] = 24'($urandom);
    mem[0]  = 24'h00F800;  // 565 pure red
    mem[1]  = 24'h0007E0;  // 565 pure green
    mem[2]  = 24'h000080;  // gray 0x80
    mem[3]  = 24'h00001F;  // 565 pure blue
    mem[31] = 24'hFFFFFF;  // last address

    repeat (3) @(negedge CLOCK_50);
    #1 reset_check("por");

    // Session A: every mode once, then random modes.
    ms = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b00, 2'($urandom), 2'($urandom)};
    start_session(ms[0]);
    for (int k = 0; k < ms.size(); k++)
      frame_body(k, (k + 1 < ms.size()) ? ms[k + 1] : 2'b00, k + 1 < ms.size());
    end_checks("sessA");
    @(negedge CLOCK_50);
    RESET = 1'b1;
    #1 reset_check("rst_blank");
    exp_q.delete();
    fmode_q.delete();
    repeat (2) @(negedge CLOCK_50);

    // Session B: bars then 565; reset lands inside an active line.
    start_session(2'b11);
    frame_body(0, 2'b01, 1'b1);
    wait_pc(1 + FRAME_CYC + CLK_DIV * (2 * H_TOT + 3));
    RESET = 1'b1;
    #1 reset_check("rst_midline");
    exp_q.delete();
    fmode_q.delete();
    repeat (2) @(negedge CLOCK_50);

    // Session C: restart after mid-line reset.
    start_session(2'b10);
    frame_body(0, 2'($urandom), 1'b1);
    frame_body(1, 2'b00, 1'b0);
    end_checks("sessC");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
